// File: rtl/axil_regbank_pkg.sv
// Shared response codes, address-decode result type and width helper for the
// AXI-Lite register bank.
package axil_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    DEC_RW,
    DEC_RO,
    DEC_EVT,
    DEC_OOR,
    DEC_MISS
  } dec_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/axil_hold_stage.sv
// One-entry holding register for an AXI-Lite request channel: ready is the
// registered "empty" flag, the entry is released by pop_i once consumed.
module axil_hold_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             eclk,
  input  logic             nrst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             pop_i
);

  logic             ready_q, ready_d;
  logic [WIDTH-1:0] data_q, data_d;

  // pop_i only arrives while full, so it never collides with a fill
  always_comb begin
    ready_d = ready_q;
    data_d  = data_q;
    if (pop_i) ready_d = 1'b1;
    if (valid_i && ready_q) begin
      ready_d = 1'b0;
      data_d  = data_i;
    end
  end

  always_ff @(posedge eclk or negedge nrst) begin
    if (!nrst) begin
      ready_q <= 1'b1;
      data_q  <= '0;
    end else begin
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

  assign ready_o = ready_q;
  assign full_o  = !ready_q;
  assign data_o  = data_q;

endmodule

// File: rtl/axil_regbank_slave.sv
// AXI-Lite slave register bank: N_RW control registers followed by N_RO status
// words. Optional AXIL_REGBANK_RDCLR_EN adds a read-to-clear sticky event register.
module axil_regbank_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned N_RW       = 8,
  parameter int unsigned N_RO       = 4,
  parameter logic [31:0] RW_RESET   = 32'h0000_0000
) (
  input  logic                 eclk,
  input  logic                 nrst,
  input  logic [31:0]          s_axil_awaddr,
  input  logic                 s_axil_awvalid,
  output logic                 s_axil_awready,
  input  logic [31:0]          s_axil_wdata,
  input  logic [3:0]           s_axil_wstrb,
  input  logic                 s_axil_wvalid,
  output logic                 s_axil_wready,
  output logic [1:0]           s_axil_bresp,
  output logic                 s_axil_bvalid,
  input  logic                 s_axil_bready,
  input  logic [31:0]          s_axil_araddr,
  input  logic                 s_axil_arvalid,
  output logic                 s_axil_arready,
  output logic [31:0]          s_axil_rdata,
  output logic [1:0]           s_axil_rresp,
  output logic                 s_axil_rvalid,
  input  logic                 s_axil_rready,
  output logic [N_RW*32-1:0]   ctrl_o,
  output logic [N_RW-1:0]      ctrl_wr_pulse,
  input  logic [N_RO*32-1:0]   status_i
`ifdef AXIL_REGBANK_RDCLR_EN
  ,
  input  logic [31:0]          event_i
`endif
);

  import axil_regbank_pkg::*;

  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned SPAN_W = clog2(N_RW + N_RO + 1);
  localparam int unsigned CMP_W  = (IDX_W > SPAN_W) ? IDX_W : SPAN_W;

  function automatic dec_e decode(input logic [31:2] a);
    logic [CMP_W-1:0] idx;
    idx = CMP_W'(a[ADDR_WIDTH-1:2]);
    if (({a, 2'b00} >> ADDR_WIDTH) != (BASE_ADDR >> ADDR_WIDTH)) return DEC_MISS;
    if (idx < CMP_W'(N_RW)) return DEC_RW;
    if (idx < CMP_W'(N_RW + N_RO)) return DEC_RO;
`ifdef AXIL_REGBANK_RDCLR_EN
    if (idx == CMP_W'(N_RW + N_RO)) return DEC_EVT;
`endif
    return DEC_OOR;
  endfunction

  logic                   aw_full, w_full, commit;
  logic [31:0]            aw_data;
  logic [35:0]            w_data;
  logic [31:0]            wmask;
  dec_e                   wdec, rdec;
  logic [CMP_W-1:0]       widx, ridx;
  logic                   ar_hs;

  logic [N_RW-1:0][31:0]  ctrl_q, ctrl_d;
  logic [N_RW-1:0]        pulse_q, pulse_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   rvalid_q, rvalid_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [31:0]            rdata_q, rdata_d;

  logic                   unused_addr_lsbs;
  assign unused_addr_lsbs = ^{aw_data[1:0], s_axil_araddr[1:0]};

  axil_hold_stage #(.WIDTH(32)) u_aw_stage (
    .eclk    (eclk),
    .nrst    (nrst),
    .valid_i (s_axil_awvalid),
    .ready_o (s_axil_awready),
    .data_i  (s_axil_awaddr),
    .full_o  (aw_full),
    .data_o  (aw_data),
    .pop_i   (commit)
  );

  axil_hold_stage #(.WIDTH(36)) u_w_stage (
    .eclk    (eclk),
    .nrst    (nrst),
    .valid_i (s_axil_wvalid),
    .ready_o (s_axil_wready),
    .data_i  ({s_axil_wstrb, s_axil_wdata}),
    .full_o  (w_full),
    .data_o  (w_data),
    .pop_i   (commit)
  );

  // Write commit: both stages full and the previous response already taken
  always_comb begin
    commit   = aw_full && w_full && !bvalid_q;
    wdec     = decode(aw_data[31:2]);
    widx     = CMP_W'(aw_data[ADDR_WIDTH-1:2]);
    wmask    = {{8{w_data[35]}}, {8{w_data[34]}}, {8{w_data[33]}}, {8{w_data[32]}}};
    ctrl_d   = ctrl_q;
    pulse_d  = '0;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (bvalid_q && s_axil_bready) bvalid_d = 1'b0;
    if (commit) begin
      bvalid_d = 1'b1;
      case (wdec)
        DEC_RW: begin
          bresp_d = RESP_OKAY;
          for (int unsigned i = 0; i < N_RW; i++) begin
            if (widx == CMP_W'(i)) begin
              ctrl_d[i]  = (ctrl_q[i] & ~wmask) | (w_data[31:0] & wmask);
              pulse_d[i] = 1'b1;
            end
          end
        end
        DEC_MISS: bresp_d = RESP_DECERR;
        default:  bresp_d = RESP_SLVERR;
      endcase
    end
  end

`ifdef AXIL_REGBANK_RDCLR_EN
  logic [31:0] evt_q, evt_d;

  // Clear-on-read happens at the AR edge; events in that same cycle survive
  always_comb begin
    evt_d = ((ar_hs && (rdec == DEC_EVT)) ? '0 : evt_q) | event_i;
  end

  always_ff @(posedge eclk or negedge nrst) begin
    if (!nrst) evt_q <= '0;
    else       evt_q <= evt_d;
  end
`endif

  // Read path samples ctrl_q, so a same-edge write is not yet visible
  always_comb begin
    ar_hs    = s_axil_arvalid && !rvalid_q;
    rdec     = decode(s_axil_araddr[31:2]);
    ridx     = CMP_W'(s_axil_araddr[ADDR_WIDTH-1:2]);
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_axil_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
      case (rdec)
        DEC_RW: begin
          for (int unsigned i = 0; i < N_RW; i++) begin
            if (ridx == CMP_W'(i)) rdata_d = ctrl_q[i];
          end
        end
        DEC_RO: begin
          for (int unsigned j = 0; j < N_RO; j++) begin
            if (ridx == CMP_W'(N_RW + j)) rdata_d = status_i[32*j +: 32];
          end
        end
`ifdef AXIL_REGBANK_RDCLR_EN
        DEC_EVT: rdata_d = evt_q;
`endif
        DEC_MISS: rresp_d = RESP_DECERR;
        default:  rresp_d = RESP_SLVERR;
      endcase
    end
  end

  always_ff @(posedge eclk or negedge nrst) begin
    if (!nrst) begin
      ctrl_q   <= {N_RW{RW_RESET}};
      pulse_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      pulse_q  <= pulse_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  assign ctrl_o         = ctrl_q;
  assign ctrl_wr_pulse  = pulse_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_arready = !rvalid_q;

endmodule

// File: tb/tb_axil_regbank_slave.sv
// Bench for axil_regbank_slave: directed vector table, hand-written corner
// sequences and randomized traffic against an address-map reference model.
module tb_axil_regbank_slave;

  localparam int unsigned N_RW = 8;
  localparam int unsigned N_RO = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] RSTV = 32'h0000_0000;
  localparam logic [1:0]  OK   = 2'b00;
  localparam logic [1:0]  SLV  = 2'b10;
  localparam logic [1:0]  DEC  = 2'b11;
`ifdef AXIL_REGBANK_RDCLR_EN
  localparam bit HAS_EVT = 1'b1;
`else
  localparam bit HAS_EVT = 1'b0;
`endif

  logic eclk = 1'b0;
  logic nrst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  logic [N_RW*32-1:0] ctrl;
  logic [N_RW-1:0]    pulse;
  logic [N_RO-1:0][31:0] stat;
  logic [31:0] evt_drv;

  always #5 eclk = ~eclk;

  axil_regbank_slave #(
    .BASE_ADDR  (BASE),
    .ADDR_WIDTH (8),
    .N_RW       (N_RW),
    .N_RO       (N_RO),
    .RW_RESET   (RSTV)
  ) dut (
    .eclk           (eclk),
    .nrst           (nrst),
    .s_axil_awaddr  (awaddr),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .ctrl_o         (ctrl),
    .ctrl_wr_pulse  (pulse),
    .status_i       (stat)
`ifdef AXIL_REGBANK_RDCLR_EN
    ,
    .event_i        (evt_drv)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_ctrl [N_RW];
  logic [31:0] m_evt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned idx_of(input logic [31:0] addr);
    return (addr >> 2) & 32'd63;
  endfunction

  function automatic logic [1:0] m_resp(input logic [31:0] addr, input bit is_wr);
    int unsigned idx;
    idx = idx_of(addr);
    if ((addr >> 8) != (BASE >> 8)) return DEC;
    if (idx < N_RW) return OK;
    if (idx < N_RW + N_RO) return is_wr ? SLV : OK;
    if (HAS_EVT && idx == N_RW + N_RO) return is_wr ? SLV : OK;
    return SLV;
  endfunction

  function automatic logic [31:0] m_rval(input logic [31:0] addr);
    int unsigned idx;
    idx = idx_of(addr);
    if (m_resp(addr, 1'b0) != OK) return 32'h0;
    if (idx < N_RW) return m_ctrl[idx];
    if (idx < N_RW + N_RO) return stat[idx - N_RW];
    return m_evt;
  endfunction

  task automatic chk_ctrl(input string tag);
    for (int i = 0; i < N_RW; i++)
      chk($sformatf("%s ctrl[%0d]", tag, i), ctrl[32*i +: 32], m_ctrl[i]);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input string tag,
                          output logic [1:0] resp);
    bit aw_done, w_done, aw_fire, w_fire;
    int c;
    logic [1:0] er;
    logic [N_RW-1:0] ep;
    logic [31:0] m;
    aw_done = 1'b0;
    w_done  = 1'b0;
    er = m_resp(addr, 1'b1);
    ep = '0;
    if (er == OK) ep[idx_of(addr)] = 1'b1;
    c = 0;
    while (!(aw_done && w_done) && c < 50) begin
      if (!aw_done && c >= aw_dly) begin awvalid = 1'b1; awaddr = addr; end
      if (!w_done && c >= w_dly) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge eclk); @(negedge eclk);
      if (aw_fire) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_fire)  begin w_done  = 1'b1; wvalid  = 1'b0; end
      c++;
    end
    if (!(aw_done && w_done)) chk({tag, " handshake timeout"}, 32'd0, 32'd1);
    chk({tag, " bvalid early"}, 32'(bvalid), 32'd0);
    c = 0;
    while (!bvalid && c < 20) begin
      @(posedge eclk); @(negedge eclk);
      c++;
    end
    chk({tag, " b latency"}, 32'(c), 32'd1);
    chk({tag, " bresp"}, 32'(bresp), 32'(er));
    chk({tag, " pulse"}, 32'(pulse), 32'(ep));
    resp = bresp;
    if (er == OK) begin
      m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      m_ctrl[idx_of(addr)] = (m_ctrl[idx_of(addr)] & ~m) | (data & m);
    end
    if (bready) begin
      @(posedge eclk); @(negedge eclk);
      chk({tag, " bvalid drop"}, 32'(bvalid), 32'd0);
      chk({tag, " pulse drop"}, 32'(pulse), 32'd0);
    end
    chk_ctrl(tag);
  endtask

  task automatic do_read(input logic [31:0] addr, input int rdly, input logic [31:0] evt_at_ar,
                         input string tag, output logic [31:0] data, output logic [1:0] resp);
    int c;
    logic [1:0] er;
    logic [31:0] ed;
    er = m_resp(addr, 1'b0);
    ed = m_rval(addr);
    rready  = 1'b0;
    arvalid = 1'b1;
    araddr  = addr;
    evt_drv = evt_at_ar;
    c = 0;
    while (!arready && c < 20) begin
      @(posedge eclk); @(negedge eclk);
      c++;
    end
    if (!arready) chk({tag, " arready timeout"}, 32'd0, 32'd1);
    @(posedge eclk); @(negedge eclk);
    arvalid = 1'b0;
    evt_drv = '0;
    if (HAS_EVT && er == OK && idx_of(addr) == N_RW + N_RO) m_evt = evt_at_ar;
    else m_evt = m_evt | evt_at_ar;
    chk({tag, " rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, " rdata"}, rdata, ed);
    chk({tag, " rresp"}, 32'(rresp), 32'(er));
    data = rdata;
    resp = rresp;
    for (int k = 0; k < rdly; k++) begin
      @(posedge eclk); @(negedge eclk);
      chk({tag, " rvalid held"}, 32'(rvalid), 32'd1);
      chk({tag, " arready held low"}, 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(posedge eclk); @(negedge eclk);
    chk({tag, " rvalid drop"}, 32'(rvalid), 32'd0);
    chk({tag, " arready back"}, 32'(arready), 32'd1);
    rready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  exp_b;
    logic [31:0] raddr;
    int          rdly;
    logic [31:0] exp_rd;
    logic [1:0]  exp_r;
  } vec_t;

  vec_t tbl [8];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] d, old;
    tbl[0] = '{32'h04, 32'hA5A5A5A5, 4'hF, 0, 3, OK,  32'h04, 0, 32'hA5A5A5A5, OK};
    tbl[1] = '{32'h00, 32'h12345678, 4'h5, 2, 0, OK,  32'h00, 0, 32'h00340078, OK};
    tbl[2] = '{32'h20, 32'hDEADBEEF, 4'hF, 0, 0, SLV, 32'h24, 4, 32'hCAFEF00D, OK};
    tbl[3] = '{32'h3C, 32'h11111111, 4'hF, 1, 1, SLV, 32'h3C, 0, 32'h0, SLV};
    tbl[4] = '{32'h10000000, 32'h22222222, 4'hF, 0, 0, DEC, 32'h10000004, 1, 32'h0, DEC};
    tbl[5] = '{32'h1E, 32'h89ABCDEF, 4'h8, 0, 2, OK,  32'h1C, 0, 32'h89000000, OK};
    tbl[6] = '{32'h05, 32'hFFFFFFFF, 4'h0, 0, 0, OK,  32'h04, 0, 32'hA5A5A5A5, OK};
    tbl[7] = '{32'h30, 32'h33333333, 4'hF, 0, 0, SLV, 32'h30, 0, 32'h0, HAS_EVT ? OK : SLV};

    nrst = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    bready = 1'b1; rready = 1'b0; evt_drv = '0;
    for (int j = 0; j < N_RO; j++) stat[j] = 32'hCAFE_0000 + 32'(j);
    stat[1] = 32'hCAFEF00D;
    for (int i = 0; i < N_RW; i++) m_ctrl[i] = RSTV;
    m_evt = '0;

    repeat (3) @(negedge eclk);
    chk("reset awready", 32'(awready), 32'd1);
    chk("reset wready", 32'(wready), 32'd1);
    chk("reset arready", 32'(arready), 32'd1);
    chk("reset bvalid", 32'(bvalid), 32'd0);
    chk("reset rvalid", 32'(rvalid), 32'd0);
    chk("reset resp", 32'({bresp, rresp}), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset pulse", 32'(pulse), 32'd0);
    chk_ctrl("reset");
    nrst = 1'b1;
    @(negedge eclk);

    for (int v = 0; v < 8; v++) begin
      do_write(tbl[v].waddr, tbl[v].wdata, tbl[v].wstrb, tbl[v].aw_dly, tbl[v].w_dly,
               $sformatf("vec%0d wr", v), r);
      chk($sformatf("vec%0d table bresp", v), 32'(r), 32'(tbl[v].exp_b));
      do_read(tbl[v].raddr, tbl[v].rdly, 32'h0, $sformatf("vec%0d rd", v), d, r);
      chk($sformatf("vec%0d table rdata", v), d, tbl[v].exp_rd);
      chk($sformatf("vec%0d table rresp", v), 32'(r), 32'(tbl[v].exp_r));
    end

    // Reset while B is pending and a second AW is parked in its stage
    bready = 1'b0;
    do_write(32'h08, 32'h5555AAAA, 4'hF, 0, 0, "rst wr", r);
    awvalid = 1'b1; awaddr = 32'h0C;
    @(posedge eclk); @(negedge eclk);
    chk("rst aw parked", 32'(awready), 32'd0);
    chk("rst bvalid pending", 32'(bvalid), 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("rst async bvalid", 32'(bvalid), 32'd0);
    chk("rst async rvalid", 32'(rvalid), 32'd0);
    chk("rst async awready", 32'(awready), 32'd1);
    chk("rst async wready", 32'(wready), 32'd1);
    for (int i = 0; i < N_RW; i++) m_ctrl[i] = RSTV;
    m_evt = '0;
    chk_ctrl("rst async");
    awvalid = 1'b0;
    bready  = 1'b1;
    @(negedge eclk);
    nrst = 1'b1;
    @(negedge eclk);
    do_write(32'h0C, 32'h0BADF00D, 4'hF, 1, 0, "post-rst wr", r);
    chk("post-rst bresp", 32'(r), 32'(OK));
    do_read(32'h0C, 0, 32'h0, "post-rst rd", d, r);
    chk("post-rst rdata", d, 32'h0BADF00D);

    // Read and write hitting register 2 on the same edge
    old = m_ctrl[2];
    @(negedge eclk);
    awvalid = 1'b1; awaddr = 32'h08; wvalid = 1'b1; wdata = 32'hABCD1234; wstrb = 4'hF;
    @(posedge eclk); @(negedge eclk);
    awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b1; araddr = 32'h08; rready = 1'b0;
    @(posedge eclk); @(negedge eclk);
    arvalid = 1'b0;
    chk("same-edge rvalid", 32'(rvalid), 32'd1);
    chk("same-edge rdata old", rdata, old);
    chk("same-edge bvalid", 32'(bvalid), 32'd1);
    chk("same-edge pulse", 32'(pulse), 32'h4);
    chk("same-edge ctrl2 new", ctrl[64 +: 32], 32'hABCD1234);
    m_ctrl[2] = 32'hABCD1234;
    rready = 1'b1;
    @(posedge eclk); @(negedge eclk);
    chk("same-edge rvalid drop", 32'(rvalid), 32'd0);
    chk("same-edge bvalid drop", 32'(bvalid), 32'd0);
    rready = 1'b0;

    if (HAS_EVT) begin
      evt_drv = 32'h11;
      @(posedge eclk); @(negedge eclk);
      evt_drv = '0;
      m_evt = m_evt | 32'h11;
      repeat (2) @(negedge eclk);
      do_read(32'h30, 0, 32'h10, "evt rd1", d, r);
      chk("evt rd1 value", d, 32'h11);
      do_read(32'h30, 0, 32'h0, "evt rd2", d, r);
      chk("evt rd2 value", d, 32'h10);
      do_read(32'h30, 0, 32'h0, "evt rd3", d, r);
      chk("evt rd3 value", d, 32'h0);
    end

    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_0100;
      else a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) stat[$urandom_range(0, N_RO-1)] = $urandom;
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $sformatf("rnd%0d wr", n), r);
      else
        do_read(a, $urandom_range(0, 2), 32'h0, $sformatf("rnd%0d rd", n), d, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
